// File: rtl/mtm_alu_pkg.sv
// Shared constants, frame FSM state type and CRC helper for the mtm ALU input stage.
package mtm_alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  localparam logic [2:0] ERR_NONE = 3'b000;
  localparam logic [2:0] ERR_DATA = 3'b100;
  localparam logic [2:0] ERR_CRC  = 3'b010;
  localparam logic [2:0] ERR_OP   = 3'b001;

  localparam logic [3:0] PKT_BYTES = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_STOP = 2'd3
  } frame_state_t;

  // CRC-4 over 68 bits, MSB first, zero initial value; poly excludes the implicit x^4 term.
  function automatic logic [3:0] crc4(input logic [67:0] data, input logic [3:0] poly);
    logic [3:0] crc;
    logic       fb;
    crc = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      fb  = crc[3] ^ data[i];
      crc = {crc[2:0], 1'b0};
      if (fb) crc = crc ^ poly;
    end
    return crc;
  endfunction

  function automatic logic op_supported(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/mtm_alu_frame_rx.sv
// Bit-level receiver for one 11-bit frame: start, cmd, 8 payload bits LSB first, stop.
// state   | meaning
// IDLE    | line idle, waiting for a start bit (sin=0)
// CMD     | sampling the cmd bit (0 = DATA, 1 = CTL)
// DATA    | shifting in 8 payload bits, LSB first
// STOP    | sampling the stop bit; frame_done is high for this cycle
module mtm_alu_frame_rx
  import mtm_alu_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sin,
  output logic [7:0] o_byte,
  output logic       o_is_ctl,
  output logic       o_frame_ok,
  output logic       o_frame_done
);

  frame_state_t r_state;
  frame_state_t w_state_nxt;
  logic [2:0]   r_bit_cnt;
  logic [7:0]   r_byte;
  logic         r_cmd;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (!i_sin) w_state_nxt = ST_CMD;
      ST_CMD:  w_state_nxt = ST_DATA;
      ST_DATA: if (r_bit_cnt == 3'd7) w_state_nxt = ST_STOP;
      ST_STOP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Cmd latch, payload shifter and bit counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bit_cnt <= 3'd0;
      r_byte    <= 8'h00;
      r_cmd     <= 1'b0;
    end else begin
      case (r_state)
        ST_CMD: begin
          r_cmd     <= i_sin;
          r_bit_cnt <= 3'd0;
        end
        ST_DATA: begin
          r_byte    <= {i_sin, r_byte[7:1]};
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // The stop bit is judged combinationally so the packet logic can act on the same edge.
  assign o_byte       = r_byte;
  assign o_is_ctl     = r_cmd;
  assign o_frame_done = (r_state == ST_STOP);
  assign o_frame_ok   = i_sin;

endmodule

// File: rtl/mtm_alu_deserializer.sv
// Packet assembly and checking: collects 8 DATA bytes into {B,A}, validates on the CTL frame.
module mtm_alu_deserializer
  import mtm_alu_pkg::*;
#(
  parameter logic [3:0] CRC_POLY = 4'b0011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic        out_valid,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [2:0]  out_op,
  output logic [2:0]  out_err
);

  logic [7:0]  w_byte;
  logic        w_is_ctl;
  logic        w_frame_ok;
  logic        w_frame_done;
  logic        w_data_evt;
  logic        w_ctl_evt;
  logic        w_bad_evt;
  logic [2:0]  w_op;
  logic [3:0]  w_crc_calc;
  logic [2:0]  w_err;

  logic [63:0] r_shift;
  logic [3:0]  r_count;
  logic        r_ovf;
  logic        r_abort;

  mtm_alu_frame_rx u_frame_rx (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_sin        (sin),
    .o_byte       (w_byte),
    .o_is_ctl     (w_is_ctl),
    .o_frame_ok   (w_frame_ok),
    .o_frame_done (w_frame_done)
  );

  assign w_data_evt = w_frame_done &&  w_frame_ok && !w_is_ctl;
  assign w_ctl_evt  = w_frame_done &&  w_frame_ok &&  w_is_ctl;
  assign w_bad_evt  = w_frame_done && !w_frame_ok;
  assign w_op       = w_byte[6:4];
  assign w_crc_calc = crc4({r_shift, 1'b1, w_op}, CRC_POLY);

  // Error code for the CTL frame currently on its stop bit, in priority order.
  always_comb begin
    w_err = ERR_NONE;
    if ((r_count != PKT_BYTES) || r_ovf || r_abort) w_err = ERR_DATA;
    else if (w_byte[3:0] != w_crc_calc)             w_err = ERR_CRC;
    else if (!op_supported(w_op))                   w_err = ERR_OP;
  end

  // Packet accumulation: operand shift register, byte count and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= 64'h0;
      r_count <= 4'd0;
      r_ovf   <= 1'b0;
      r_abort <= 1'b0;
    end else if (w_ctl_evt) begin
      r_count <= 4'd0;
      r_ovf   <= 1'b0;
      r_abort <= 1'b0;
    end else if (w_bad_evt) begin
      r_abort <= 1'b1;
    end else if (w_data_evt) begin
      if (r_count < PKT_BYTES) begin
        r_shift <= {r_shift[55:0], w_byte};
        r_count <= r_count + 4'd1;
      end else begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Output registers: loaded on every good CTL stop bit, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_a     <= 32'h0;
      out_b     <= 32'h0;
      out_op    <= 3'b000;
      out_err   <= ERR_NONE;
    end else begin
      out_valid <= w_ctl_evt;
      if (w_ctl_evt) begin
        out_b   <= r_shift[63:32];
        out_a   <= r_shift[31:0];
        out_op  <= w_op;
        out_err <= w_err;
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Directed bench for the mtm ALU deserializer.
module tb_mtm_alu_deserializer;

  logic        clk;
  logic        rst;
  logic        sin;
  logic        out_valid;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_op;
  logic [2:0]  out_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;
  int p0;

  mtm_alu_deserializer dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .out_valid (out_valid),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_op    (out_op),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A one-cycle strobe is seen at exactly one falling edge.
  always @(negedge clk) if (out_valid === 1'b1) n_pulses++;

  // Reference CRC as polynomial long division of data*x^4 by x^4+x+1.
  function automatic logic [3:0] model_crc(input logic [31:0] b, input logic [31:0] a,
                                           input logic [2:0] op);
    logic [71:0] r;
    r = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic cmd, input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    send_bit(cmd);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  // n DATA frames taken from {b,a} MSB byte first (wrapping past 8); bad_idx gets stop=0.
  task automatic send_data(input logic [31:0] b, input logic [31:0] a, input int n,
                           input int bad_idx);
    logic [63:0] v;
    v = {b, a};
    for (int k = 0; k < n; k++)
      send_frame(1'b0, v[63 - 8*(k % 8) -: 8], (k == bad_idx) ? 1'b0 : 1'b1);
  endtask

  task automatic send_ctl(input logic [2:0] op, input logic [3:0] crc);
    send_frame(1'b1, {1'b0, op, crc}, 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    sin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_checks++; if (out_a !== 32'h0) begin n_errors++; $display("FAIL reset_a got=%h exp=0", out_a); end
    n_checks++; if (out_b !== 32'h0) begin n_errors++; $display("FAIL reset_b got=%h exp=0", out_b); end
    n_checks++; if (out_op !== 3'b000) begin n_errors++; $display("FAIL reset_op got=%b exp=000", out_op); end
    n_checks++; if (out_err !== 3'b000) begin n_errors++; $display("FAIL reset_err got=%b exp=000", out_err); end
    rst = 1'b0;
    repeat (2) send_bit(1'b1);
  endtask

  task automatic test_valid_packet;
    p0 = n_pulses;
    send_data(32'h00000001, 32'h00000002, 8, -1);
    send_ctl(3'b100, model_crc(32'h00000001, 32'h00000002, 3'b100));
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL valid_latency got=%b exp=1", out_valid); end
    send_bit(1'b1);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL valid_width got=%b exp=0", out_valid); end
    send_bit(1'b1);
    n_checks++; if (n_pulses - p0 !== 1) begin n_errors++; $display("FAIL valid_pulses got=%0d exp=1", n_pulses - p0); end
    n_checks++; if (out_a !== 32'h00000002) begin n_errors++; $display("FAIL valid_a got=%h exp=00000002", out_a); end
    n_checks++; if (out_b !== 32'h00000001) begin n_errors++; $display("FAIL valid_b got=%h exp=00000001", out_b); end
    n_checks++; if (out_op !== 3'b100) begin n_errors++; $display("FAIL valid_op got=%b exp=100", out_op); end
    n_checks++; if (out_err !== 3'b000) begin n_errors++; $display("FAIL valid_err got=%b exp=000", out_err); end
  endtask

  task automatic test_boundary;
    logic [2:0] ops [4];
    ops = '{3'b000, 3'b001, 3'b100, 3'b101};
    for (int i = 0; i < 4; i++) begin
      send_data(32'h00000000, 32'hFFFFFFFF, 8, -1);
      send_ctl(ops[i], model_crc(32'h00000000, 32'hFFFFFFFF, ops[i]));
      send_bit(1'b1);
      n_checks++; if (out_err !== 3'b000) begin n_errors++; $display("FAIL bound_err op=%b got=%b exp=000", ops[i], out_err); end
      n_checks++; if (out_a !== 32'hFFFFFFFF) begin n_errors++; $display("FAIL bound_a op=%b got=%h exp=ffffffff", ops[i], out_a); end
      n_checks++; if (out_b !== 32'h00000000) begin n_errors++; $display("FAIL bound_b op=%b got=%h exp=00000000", ops[i], out_b); end
      n_checks++; if (out_op !== ops[i]) begin n_errors++; $display("FAIL bound_op got=%b exp=%b", out_op, ops[i]); end
    end
  endtask

  task automatic test_crc_err;
    p0 = n_pulses;
    send_data(32'h00000001, 32'h00000002, 8, -1);
    send_ctl(3'b100, model_crc(32'h00000001, 32'h00000002, 3'b100) ^ 4'h1);
    send_bit(1'b1);
    send_bit(1'b1);
    n_checks++; if (out_err !== 3'b010) begin n_errors++; $display("FAIL crc_err got=%b exp=010", out_err); end
    n_checks++; if (n_pulses - p0 !== 1) begin n_errors++; $display("FAIL crc_pulses got=%0d exp=1", n_pulses - p0); end
    n_checks++; if (out_a !== 32'h00000002) begin n_errors++; $display("FAIL crc_a got=%h exp=00000002", out_a); end
  endtask

  task automatic test_count;
    send_data(32'h12345678, 32'h9ABCDEF0, 7, -1);
    send_ctl(3'b100, model_crc(32'h12345678, 32'h9ABCDEF0, 3'b100));
    send_bit(1'b1);
    n_checks++; if (out_err !== 3'b100) begin n_errors++; $display("FAIL short_err got=%b exp=100", out_err); end
    send_data(32'h12345678, 32'h9ABCDEF0, 9, -1);
    send_ctl(3'b100, model_crc(32'h12345678, 32'h9ABCDEF0, 3'b100));
    send_bit(1'b1);
    n_checks++; if (out_err !== 3'b100) begin n_errors++; $display("FAIL long_err got=%b exp=100", out_err); end
    n_checks++; if (out_b !== 32'h12345678) begin n_errors++; $display("FAIL long_b got=%h exp=12345678", out_b); end
    send_data(32'h12345678, 32'h9ABCDEF0, 8, -1);
    send_ctl(3'b101, model_crc(32'h12345678, 32'h9ABCDEF0, 3'b101));
    send_bit(1'b1);
    n_checks++; if (out_err !== 3'b000) begin n_errors++; $display("FAIL recover_err got=%b exp=000", out_err); end
    n_checks++; if (out_a !== 32'h9ABCDEF0) begin n_errors++; $display("FAIL recover_a got=%h exp=9abcdef0", out_a); end
    n_checks++; if (out_b !== 32'h12345678) begin n_errors++; $display("FAIL recover_b got=%h exp=12345678", out_b); end
  endtask

  task automatic test_op_and_framing;
    send_data(32'hCAFEF00D, 32'h00C0FFEE, 8, -1);
    send_ctl(3'b010, model_crc(32'hCAFEF00D, 32'h00C0FFEE, 3'b010));
    send_bit(1'b1);
    n_checks++; if (out_err !== 3'b001) begin n_errors++; $display("FAIL op_err got=%b exp=001", out_err); end
    n_checks++; if (out_op !== 3'b010) begin n_errors++; $display("FAIL op_val got=%b exp=010", out_op); end
    send_data(32'h00000001, 32'h00000002, 8, 3);
    send_ctl(3'b100, model_crc(32'h00000001, 32'h00000002, 3'b100));
    send_bit(1'b1);
    n_checks++; if (out_err !== 3'b100) begin n_errors++; $display("FAIL frame_err got=%b exp=100", out_err); end
  endtask

  task automatic test_mid_reset;
    send_data(32'hA5A5A5A5, 32'h5A5A5A5A, 8, -1);
    send_ctl(3'b001, model_crc(32'hA5A5A5A5, 32'h5A5A5A5A, 3'b001));
    send_bit(1'b1);
    n_checks++; if (out_a !== 32'h5A5A5A5A) begin n_errors++; $display("FAIL pre_rst_a got=%h exp=5a5a5a5a", out_a); end
    send_data(32'h11111111, 32'h22222222, 4, -1);
    rst = 1'b1;
    #1;
    n_checks++; if (out_a !== 32'h0) begin n_errors++; $display("FAIL mrst_a got=%h exp=0", out_a); end
    n_checks++; if (out_b !== 32'h0) begin n_errors++; $display("FAIL mrst_b got=%h exp=0", out_b); end
    n_checks++; if (out_op !== 3'b000) begin n_errors++; $display("FAIL mrst_op got=%b exp=000", out_op); end
    n_checks++; if (out_err !== 3'b000) begin n_errors++; $display("FAIL mrst_err got=%b exp=000", out_err); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_bit(1'b1);
    p0 = n_pulses;
    send_data(32'h0000FFFF, 32'hFFFF0000, 8, -1);
    send_ctl(3'b000, model_crc(32'h0000FFFF, 32'hFFFF0000, 3'b000));
    send_bit(1'b1);
    n_checks++; if (out_err !== 3'b000) begin n_errors++; $display("FAIL post_rst_err got=%b exp=000", out_err); end
    n_checks++; if (out_a !== 32'hFFFF0000) begin n_errors++; $display("FAIL post_rst_a got=%h exp=ffff0000", out_a); end
    n_checks++; if (out_b !== 32'h0000FFFF) begin n_errors++; $display("FAIL post_rst_b got=%h exp=0000ffff", out_b); end
    n_checks++; if (n_pulses - p0 !== 1) begin n_errors++; $display("FAIL post_rst_pulses got=%0d exp=1", n_pulses - p0); end
  endtask

  initial begin
    test_reset();
    test_valid_packet();
    test_boundary();
    test_crc_err();
    test_count();
    test_op_and_framing();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
